veripac_run_ctrl: RTL and testbench

Run/step sequencer and bus arbiter placed in front of the veripac9 core port. It shares the core's single addr/rd/wr/din/dout port between the host (ZX-Uno register interface) and an internal run engine. The engine issues clean step pulses at a programmable rate, polls core state after each step, and stops on HALT, breakpoint, stop command or single-step completion. The host keeps register/RAM access at all times, with a wait signal while the engine holds the bus.

---
 rtl/veripac_run_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_veripac_run_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/veripac_run_ctrl.sv
// Run/step sequencer and host/engine arbiter for the single veripac9 core port.
// Define VERIPAC_BREAKPOINT_EN to add the PC poll state and the breakpoint stop.
module veripac_run_ctrl #(
   parameter logic [7:0] CTRL_ADDR = 8'hCA,
   parameter logic [7:0] PC_ADDR   = 8'hCD,
   parameter int         RATE_W    = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [7:0]        hst_addr,
   input  logic              hst_rd,
   input  logic              hst_wr,
   input  logic [7:0]        hst_din,
   output logic [7:0]        hst_dout,
   output logic              hst_wait,
   input  logic              cmd_run,
   input  logic              cmd_step,
   input  logic              cmd_stop,
   input  logic              cmd_reset,
   input  logic [RATE_W-1:0] rate,
   input  logic [7:0]        bp_addr,
   input  logic              bp_en,
   output logic [7:0]        core_addr,
   output logic              core_rd,
   output logic              core_wr,
   output logic [7:0]        core_din,
   input  logic [7:0]        core_dout,
   output logic              core_step,
   output logic              core_reset,
   output logic              running,
   output logic              halted,
   output logic              bp_hit
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_STEP_HI, S_STEP_LO, S_POLL_CTRL, S_POLL_PC, S_CRST
   } state_t;

   state_t            state_q, state_d;
   logic [RATE_W-1:0] cnt_q, cnt_d;
   logic              single_q, single_d;
   logic              stop_q, stop_d;
   logic              rst_q, rst_d;
   logic              halted_q, halted_d;
   logic              bp_hit_q, bp_hit_d;

   logic              host_own, host_act;
   logic              stop_any, rst_any, decide, pc_hit;
   logic [1:0]        uc_st;
   state_t            exit_st;

`ifdef VERIPAC_BREAKPOINT_EN
   logic [1:0]        ctrl_q, ctrl_d;
`else
   logic              unused_bp;
   assign unused_bp = ^{bp_en, bp_addr};
`endif

   assign host_own = (state_q == S_IDLE) || (state_q == S_WAIT);
   assign host_act = hst_rd | hst_wr;
   assign rst_any  = rst_q | cmd_reset;
   assign stop_any = stop_q | cmd_stop | rst_any;
   assign exit_st  = rst_any ? S_CRST : S_IDLE;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      single_d = single_q;
      stop_d   = stop_q;
      rst_d    = rst_q;
      halted_d = halted_q;
      bp_hit_d = bp_hit_q;
      decide   = 1'b0;
      pc_hit   = 1'b0;
      uc_st    = core_dout[1:0];
`ifdef VERIPAC_BREAKPOINT_EN
      ctrl_d   = ctrl_q;
`endif

      // Stop/reset requests raised while the engine owns the bus wait for the poll.
      if (!host_own) begin
         if (cmd_stop || cmd_reset) stop_d = 1'b1;
         if (cmd_reset)             rst_d  = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (cmd_reset) begin
               state_d = S_CRST;
            end else if (cmd_run || cmd_step) begin
               state_d  = S_WAIT;
               cnt_d    = cmd_run ? rate : '0;
               single_d = ~cmd_run;
               halted_d = 1'b0;
               bp_hit_d = 1'b0;
               stop_d   = 1'b0;
               rst_d    = 1'b0;
            end
         end
         S_WAIT: begin
            if (cnt_q != '0) cnt_d = cnt_q - RATE_W'(1);
            if (cmd_reset) begin
               state_d = S_CRST;
            end else if (cmd_stop) begin
               state_d = S_IDLE;
            end else if (cnt_q == '0 && !host_act) begin
               state_d = S_STEP_HI;
            end
         end
         S_STEP_HI: state_d = S_STEP_LO;
         S_STEP_LO: state_d = S_POLL_CTRL;
         S_POLL_CTRL: begin
`ifdef VERIPAC_BREAKPOINT_EN
            ctrl_d  = core_dout[1:0];
            state_d = S_POLL_PC;
`endif
         end
         S_POLL_PC: state_d = S_IDLE;
         S_CRST: begin
            state_d  = S_IDLE;
            halted_d = 1'b0;
            bp_hit_d = 1'b0;
            stop_d   = 1'b0;
            rst_d    = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase

`ifdef VERIPAC_BREAKPOINT_EN
      decide = (state_q == S_POLL_PC);
      uc_st  = ctrl_q;
      pc_hit = bp_en && (core_dout == bp_addr);
`else
      decide = (state_q == S_POLL_CTRL);
`endif

      // The WAIT reload is rate-1 (or a direct STEP_HI for rate 0) so the
      // step-to-step cadence counts exactly `rate` idle clocks.
      if (decide) begin
         if (uc_st == 2'b11) begin
            state_d  = exit_st;
            halted_d = 1'b1;
         end else if (pc_hit) begin
            state_d  = exit_st;
            bp_hit_d = 1'b1;
         end else if (stop_any || single_q) begin
            state_d = exit_st;
         end else if (rate == '0 && !host_act) begin
            state_d = S_STEP_HI;
         end else begin
            state_d = S_WAIT;
            cnt_d   = (rate == '0) ? '0 : rate - RATE_W'(1);
         end
         if (state_d == S_IDLE || state_d == S_CRST) begin
            stop_d = 1'b0;
            rst_d  = 1'b0;
         end
      end
   end

   always_comb begin
      core_addr  = 8'h00;
      core_rd    = 1'b0;
      core_wr    = 1'b0;
      core_din   = 8'h00;
      core_step  = 1'b0;
      core_reset = 1'b0;
      hst_wait   = 1'b0;
      hst_dout   = 8'h00;
      if (host_own) begin
         core_addr = hst_addr;
         core_rd   = hst_rd;
         core_wr   = hst_wr;
         core_din  = hst_din;
         hst_dout  = hst_rd ? core_dout : 8'h00;
      end else begin
         hst_wait = host_act;
         case (state_q)
            S_STEP_HI:   core_step = 1'b1;
            S_POLL_CTRL: begin
               core_addr = CTRL_ADDR;
               core_rd   = 1'b1;
            end
            S_POLL_PC: begin
               core_addr = PC_ADDR;
               core_rd   = 1'b1;
            end
            S_CRST:      core_reset = 1'b1;
            default:     core_step  = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         single_q <= 1'b0;
         stop_q   <= 1'b0;
         rst_q    <= 1'b0;
         halted_q <= 1'b0;
         bp_hit_q <= 1'b0;
`ifdef VERIPAC_BREAKPOINT_EN
         ctrl_q   <= 2'b00;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         single_q <= single_d;
         stop_q   <= stop_d;
         rst_q    <= rst_d;
         halted_q <= halted_d;
         bp_hit_q <= bp_hit_d;
`ifdef VERIPAC_BREAKPOINT_EN
         ctrl_q   <= ctrl_d;
`endif
      end
   end

   assign running = (state_q != S_IDLE);
   assign halted  = halted_q;
   assign bp_hit  = bp_hit_q;

endmodule

// File: tb/tb_veripac_run_ctrl.sv
// Directed bench for veripac_run_ctrl with a tiny behavioural core on the far side.
module tb_veripac_run_ctrl;

   localparam logic [7:0] CA = 8'hCA;
   localparam logic [7:0] CD = 8'hCD;
`ifdef VERIPAC_BREAKPOINT_EN
   localparam int BPX = 1;
`else
   localparam int BPX = 0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  hst_addr = '0, hst_din = '0, hst_dout;
   logic        hst_rd = 0, hst_wr = 0, hst_wait;
   logic        cmd_run = 0, cmd_step = 0, cmd_stop = 0, cmd_reset = 0;
   logic [15:0] rate = '0;
   logic [7:0]  bp_addr = '0;
   logic        bp_en = 0;
   logic [7:0]  core_addr, core_din, core_dout;
   logic        core_rd, core_wr, core_step, core_reset;
   logic        running, halted, bp_hit;

   logic [1:0]  uc = 2'b00;
   logic [7:0]  pc = 8'h00;
   int          cyc = 0;
   int          steps = 0;
   int          stepcyc[$];
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   veripac_run_ctrl dut (
      .clk(clk), .reset_n(reset_n),
      .hst_addr(hst_addr), .hst_rd(hst_rd), .hst_wr(hst_wr), .hst_din(hst_din),
      .hst_dout(hst_dout), .hst_wait(hst_wait),
      .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_stop(cmd_stop), .cmd_reset(cmd_reset),
      .rate(rate), .bp_addr(bp_addr), .bp_en(bp_en),
      .core_addr(core_addr), .core_rd(core_rd), .core_wr(core_wr), .core_din(core_din),
      .core_dout(core_dout), .core_step(core_step), .core_reset(core_reset),
      .running(running), .halted(halted), .bp_hit(bp_hit)
   );

   // Behavioural core: control reg, PC, and a scrambled memory everywhere else.
   assign core_dout = (core_addr == CA) ? {6'b0, uc} :
                      (core_addr == CD) ? pc : (core_addr ^ 8'hA5);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (core_reset)     pc <= 8'h00;
      else if (core_step) pc <= pc + 8'h01;
   end

   always @(negedge clk) begin
      if (core_step === 1'b1) begin
         steps = steps + 1;
         stepcyc.push_back(cyc);
      end
   end

   typedef struct {
      logic        run, step, stop, crst, hrd;
      logic [7:0]  haddr;
      logic [21:0] exp;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input logic r, s, p, c, h, input logic [7:0] ha,
                      input logic es, erd, erst, input logic [7:0] ea,
                      input logic erun, ewait, input logic [7:0] edout, input logic ehalt);
      vec_t v;
      v.run = r; v.step = s; v.stop = p; v.crst = c; v.hrd = h; v.haddr = ha;
      v.exp = {es, erd, erst, ea, erun, ewait, edout, ehalt};
      vecs.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic wait_idle(input int bound, input string name);
      int n = 0;
      while (running && n < bound) begin
         tick();
         n++;
      end
      chk(name, {31'b0, running}, 32'd0);
   endtask

   task automatic wait_step(input int bound, input string name);
      int n = 0;
      while (!core_step && n < bound) begin
         tick();
         n++;
      end
      chk(name, {31'b0, core_step}, 32'd1);
   endtask

   initial begin
      logic [21:0] got;
      int n0;
      int n;

      // Rows: run step stop crst hrd haddr | step rd rst addr run wait dout halted
      // Single step, rate 0
      add(0,0,0,0,0,8'h00, 0,0,0,8'h00,0,0,8'h00,0);
      add(0,1,0,0,0,8'h00, 0,0,0,8'h00,0,0,8'h00,0);
      add(0,0,0,0,0,8'h00, 0,0,0,8'h00,1,0,8'h00,0);
      add(0,0,0,0,0,8'h00, 1,0,0,8'h00,1,0,8'h00,0);
      add(0,0,0,0,0,8'h00, 0,0,0,8'h00,1,0,8'h00,0);
      add(0,0,0,0,0,8'h00, 0,1,0,CA,   1,0,8'h00,0);
`ifdef VERIPAC_BREAKPOINT_EN
      add(0,0,0,0,0,8'h00, 0,1,0,CD,   1,0,8'h00,0);
`endif
      add(0,0,0,0,0,8'h00, 0,0,0,8'h00,0,0,8'h00,0);
      // Host read stalled by an in-flight step
      add(0,0,0,0,1,8'h10, 0,1,0,8'h10,0,0,8'hB5,0);
      add(0,1,0,0,0,8'h00, 0,0,0,8'h00,0,0,8'h00,0);
      add(0,0,0,0,0,8'h00, 0,0,0,8'h00,1,0,8'h00,0);
      add(0,0,0,0,1,8'h10, 1,0,0,8'h00,1,1,8'h00,0);
      add(0,0,0,0,1,8'h10, 0,0,0,8'h00,1,1,8'h00,0);
      add(0,0,0,0,1,8'h10, 0,1,0,CA,   1,1,8'h00,0);
`ifdef VERIPAC_BREAKPOINT_EN
      add(0,0,0,0,1,8'h10, 0,1,0,CD,   1,1,8'h00,0);
`endif
      add(0,0,0,0,1,8'h10, 0,1,0,8'h10,0,0,8'hB5,0);
      // Host active in WAIT defers the step
      add(0,1,0,0,0,8'h00, 0,0,0,8'h00,0,0,8'h00,0);
      add(0,0,0,0,1,8'h10, 0,1,0,8'h10,1,0,8'hB5,0);
      add(0,0,0,0,1,8'h10, 0,1,0,8'h10,1,0,8'hB5,0);
      add(0,0,0,0,0,8'h00, 0,0,0,8'h00,1,0,8'h00,0);
      add(0,0,0,0,0,8'h00, 1,0,0,8'h00,1,0,8'h00,0);
      add(0,0,0,0,0,8'h00, 0,0,0,8'h00,1,0,8'h00,0);
      add(0,0,0,0,0,8'h00, 0,1,0,CA,   1,0,8'h00,0);
`ifdef VERIPAC_BREAKPOINT_EN
      add(0,0,0,0,0,8'h00, 0,1,0,CD,   1,0,8'h00,0);
`endif
      add(0,0,0,0,0,8'h00, 0,0,0,8'h00,0,0,8'h00,0);
      // Stop ignored in IDLE; stop in WAIT; reset beats run/step in IDLE
      add(0,0,1,0,0,8'h00, 0,0,0,8'h00,0,0,8'h00,0);
      add(0,0,0,0,0,8'h00, 0,0,0,8'h00,0,0,8'h00,0);
      add(1,1,0,0,0,8'h00, 0,0,0,8'h00,0,0,8'h00,0);
      add(0,0,1,0,0,8'h00, 0,0,0,8'h00,1,0,8'h00,0);
      add(0,0,0,0,0,8'h00, 0,0,0,8'h00,0,0,8'h00,0);
      add(1,1,0,1,0,8'h00, 0,0,0,8'h00,0,0,8'h00,0);
      add(0,0,0,0,0,8'h00, 0,0,1,8'h00,1,0,8'h00,0);
      add(0,0,0,0,0,8'h00, 0,0,0,8'h00,0,0,8'h00,0);

      // Reset state
      tick();
      chk("rst_running", {31'b0, running}, 0);
      chk("rst_step",    {31'b0, core_step}, 0);
      chk("rst_flags",   {30'b0, halted, bp_hit}, 0);
      chk("rst_wait",    {24'b0, hst_dout}, 0);
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < vecs.size(); i++) begin
         cmd_run = vecs[i].run; cmd_step = vecs[i].step; cmd_stop = vecs[i].stop;
         cmd_reset = vecs[i].crst; hst_rd = vecs[i].hrd; hst_addr = vecs[i].haddr;
         #1;
         got = {core_step, core_rd, core_reset, core_addr, running, hst_wait, hst_dout, halted};
         checks++;
         if (got !== vecs[i].exp) begin
            failures++;
            $display("FAIL vec[%0d] got=%0h exp=%0h", i, got, vecs[i].exp);
         end
         tick();
      end
      cmd_run = 0; cmd_step = 0; cmd_stop = 0; cmd_reset = 0; hst_rd = 0; hst_addr = 0;
      chk("table_steps", steps, 3);

      // Run cadence at rate 3, then stop during STEP_LO
      rate = 16'd3;
      stepcyc.delete();
      cmd_run = 1; tick(); cmd_run = 0;
      n = 0;
      while (stepcyc.size() < 3 && n < 80) begin
         tick();
         n++;
      end
      chk("cad_seen", {31'b0, stepcyc.size() >= 3}, 1);
      if (stepcyc.size() >= 3) begin
         chk("cad_gap1", stepcyc[1] - stepcyc[0], 6 + BPX);
         chk("cad_gap2", stepcyc[2] - stepcyc[1], 6 + BPX);
      end
      wait_step(20, "stop_find_step");
      tick();
      chk("stop_steplo", {30'b0, core_step, running}, 1);
      cmd_stop = 1; tick(); cmd_stop = 0;
      chk("stop_pollca", {core_rd, core_addr}, {1'b1, CA});
      if (BPX == 1) begin
         tick();
         chk("stop_pollcd", {core_rd, core_addr}, {1'b1, CD});
      end
      tick();
      chk("stop_idle", {31'b0, running}, 0);
      n0 = steps;
      repeat (12) tick();
      chk("stop_nostep", steps, n0);

      // HALT reported at the control poll; run clears halted
      rate = 16'd20;
      uc = 2'b11;
      n0 = steps;
      cmd_step = 1; tick(); cmd_step = 0;
      wait_idle(20, "halt_idle");
      chk("halt_set", {31'b0, halted}, 1);
      chk("halt_steps", steps - n0, 1);
      uc = 2'b00;
      cmd_run = 1; tick(); cmd_run = 0;
      chk("halt_clr_run", {30'b0, halted, running}, 1);
      cmd_stop = 1; tick(); cmd_stop = 0;
      chk("wait_stop", {31'b0, running}, 0);

      // Reset command from IDLE clears halted and zeroes the PC
      uc = 2'b11;
      cmd_step = 1; tick(); cmd_step = 0;
      wait_idle(20, "halt2_idle");
      chk("halt2_set", {31'b0, halted}, 1);
      uc = 2'b00;
      cmd_reset = 1; tick(); cmd_reset = 0;
      chk("crst_pulse", {core_reset, core_rd, core_wr}, 3'b100);
      tick();
      chk("crst_done", {core_reset, running, halted}, 3'b000);
      chk("crst_pc", {24'b0, pc}, 0);

      // Breakpoint at PC 5 from PC 0
      bp_en = 1; bp_addr = 8'h05; rate = 16'd0;
      n0 = steps;
      cmd_run = 1; tick(); cmd_run = 0;
`ifdef VERIPAC_BREAKPOINT_EN
      wait_idle(100, "bp_idle");
      chk("bp_steps", steps - n0, 5);
      chk("bp_flags", {30'b0, bp_hit, halted}, 2'b10);
      chk("bp_pc", {24'b0, pc}, 5);
`else
      repeat (40) tick();
      chk("nobp_running", {31'b0, running}, 1);
      chk("nobp_flag", {31'b0, bp_hit}, 0);
      chk("nobp_steps", {31'b0, (steps - n0) > 5}, 1);
      cmd_stop = 1; tick(); cmd_stop = 0;
      wait_idle(10, "nobp_idle");
`endif
      bp_en = 0;

      // Reset command during a run: poll completes, then one core_reset clk
      rate = 16'd2;
      cmd_run = 1; tick(); cmd_run = 0;
      wait_step(20, "crun_find_step");
      tick();
      cmd_reset = 1; tick(); cmd_reset = 0;
      chk("crun_pollca", {core_reset, core_rd, core_addr}, {2'b01, CA});
      if (BPX == 1) begin
         tick();
         chk("crun_pollcd", {core_reset, core_rd, core_addr}, {2'b01, CD});
      end
      tick();
      chk("crun_pulse", {core_reset, core_rd, core_wr, running}, 4'b1001);
      tick();
      chk("crun_done", {core_reset, running, halted, bp_hit}, 4'b0000);

      // Asynchronous reset in the middle of STEP_HI
      cmd_step = 1; tick(); cmd_step = 0;
      tick();
      chk("arst_stephi", {31'b0, core_step}, 1);
      reset_n = 1'b0;
      #1;
      chk("arst_drop", {30'b0, core_step, running}, 0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("arst_idle", {31'b0, running}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
